// File: rtl/div_share_arb.sv
// div_share_arb: shares one iterative divider between NREQ requesters.
// Requests are granted round-robin one at a time, launched on the divider with a
// single-cycle valid pulse, and answered through a one-entry response buffer.
// Flush cancels whatever is in flight. A watchdog aborts a divide that never finishes.
module div_share_arb #(
  parameter int NREQ    = 2,
  parameter int XLEN    = 32,
  parameter int TAGW    = 4,
  parameter int TIMEOUT = 64,
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int WDW    = $clog2(TIMEOUT) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_dividend,
  input  logic [NREQ*XLEN-1:0] req_divisor,
  input  logic [NREQ-1:0]      req_unsign,
  input  logic [NREQ-1:0]      req_rem,
  input  logic [NREQ*TAGW-1:0] req_tag,
  input  logic                 flush,
  output logic                 div_valid,
  output logic                 div_unsign,
  output logic                 div_rem,
  output logic [XLEN-1:0]      div_dividend,
  output logic [XLEN-1:0]      div_divisor,
  output logic                 div_flush,
  input  logic                 div_finish,
  input  logic [XLEN-1:0]      div_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [TAGW-1:0]      rsp_tag,
  output logic [XLEN-1:0]      rsp_data,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  winner;
  logic [IDW-1:0]  cand;
  logic [IDW-1:0]  next_ptr;
  logic [IDW-1:0]  id_q;
  logic            found;
  logic            grant;
  int              scan_idx;
  logic [XLEN-1:0] dividend_q;
  logic [XLEN-1:0] divisor_q;
  logic [XLEN-1:0] data_q;
  logic [TAGW-1:0] tag_q;
  logic            unsign_q;
  logic            rem_q;
  logic            to_flush_q;
  logic            timeout_q;
  logic [WDW-1:0]  wd;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    cand     = '0;
    scan_idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = (int'(rr_ptr) + k) % NREQ;
      cand     = IDW'(scan_idx);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // A grant is offered only while idle and not flushing; reset masks it too.
  assign grant     = found && (state == IDLE) && !flush && !rst;
  assign req_ready = grant ? (NREQ'(1) << winner) : '0;
  assign next_ptr  = (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;

  assign div_valid    = (state == ISSUE) && !flush;
  assign div_flush    = (((state == ISSUE) || (state == BUSY)) && flush) || to_flush_q;
  assign div_unsign   = unsign_q;
  assign div_rem      = rem_q;
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;
  assign rsp_valid    = (state == RESP);
  assign rsp_id       = id_q;
  assign rsp_tag      = tag_q;
  assign rsp_data     = data_q;
  assign timeout_err  = timeout_q;

  // Sequencer: grant, issue one pulse, wait for finish/flush/timeout, hold the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      wd         <= '0;
      id_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      unsign_q   <= 1'b0;
      rem_q      <= 1'b0;
      tag_q      <= '0;
      data_q     <= '0;
      to_flush_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      to_flush_q <= 1'b0;
      timeout_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            dividend_q <= req_dividend[int'(winner)*XLEN +: XLEN];
            divisor_q  <= req_divisor[int'(winner)*XLEN +: XLEN];
            unsign_q   <= req_unsign[winner];
            rem_q      <= req_rem[winner];
            tag_q      <= req_tag[int'(winner)*TAGW +: TAGW];
            id_q       <= winner;
            rr_ptr     <= next_ptr;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          wd    <= '0;
          state <= flush ? IDLE : BUSY;
        end
        BUSY: begin
          if (flush) begin
            state <= IDLE;
          end else if (div_finish) begin
            data_q <= div_out;
            state  <= RESP;
          end else if (wd == WDW'(TIMEOUT - 1)) begin
            timeout_q  <= 1'b1;
            to_flush_q <= 1'b1;
            state      <= IDLE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        RESP: begin
          if (flush || rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/div_share_arb.md
Name: div_share_arb

Overview:
- Arbiter/sequencer that shares one exu_div_ctl_32 divider between NREQ requesters, e.g. two issue lanes or a lane plus a debug path.
- Round-robin grants one request at a time and launches it on the divider as a one-cycle div_pkt valid pulse.
- Waits for the divider's finish, then returns the result to the granted requester through a one-entry response buffer with backpressure.
- Handles pipeline flush and a hang watchdog.

Parameters:
- NREQ, 2, number of requesters (2..8).
- XLEN, 32, operand and result width.
- TAGW, 4, requester-supplied tag width, returned unchanged.
- TIMEOUT, 64, maximum BUSY cycles before the watchdog abort.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  NREQ  request present, one bit per requester.
- req_ready  out  NREQ  grant, one-hot or zero.
- req_dividend  in  NREQ*XLEN  numerator; requester i uses slice [i*XLEN +: XLEN].
- req_divisor  in  NREQ*XLEN  denominator, same slicing.
- req_unsign  in  NREQ  unsigned operation.
- req_rem  in  NREQ  return remainder instead of quotient.
- req_tag  in  NREQ*TAGW  tag, same slicing.
- flush  in  1  pipeline flush.
- div_valid  out  1  to divider dp.valid.
- div_unsign  out  1  to divider dp.unsign.
- div_rem  out  1  to divider dp.rem.
- div_dividend  out  XLEN  to divider dividend.
- div_divisor  out  XLEN  to divider divisor.
- div_flush  out  1  to divider flush_lower.
- div_finish  in  1  divider finish.
- div_out  in  XLEN  divider result.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  $clog2(NREQ)  index of the requester being answered.
- rsp_tag  out  TAGW  echoed tag.
- rsp_data  out  XLEN  quotient or remainder.
- timeout_err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset: all outputs 0; state=IDLE; rr_ptr=0; watchdog=0; operand/tag/id registers cleared.
- States: IDLE, ISSUE, BUSY, RESP.
- IDLE arbitration:
  - Winner = first i with req_valid[i] set, searching from rr_ptr upward with wrap.
  - req_ready[winner]=1 combinationally, only in IDLE and only when flush=0.
  - Handshake = req_valid & req_ready at a clock edge. On handshake, capture operands, unsign, rem, tag and id; set rr_ptr=(winner+1) mod NREQ; go to ISSUE.
- ISSUE (exactly one cycle):
  - div_valid=1 and div_* operands driven from the registers; next state BUSY; watchdog cleared.
  - If flush=1: div_valid=0, div_flush=1, go to IDLE.
- BUSY:
  - div_valid=0; operand outputs held; watchdog increments each cycle.
  - On div_finish=1: capture div_out into rsp_data; go to RESP.
  - On flush=1: div_flush=1, discard, go to IDLE. Flush wins over a simultaneous finish.
  - If the watchdog reaches TIMEOUT-1 without finish: timeout_err=1 and div_flush=1 for one cycle, go to IDLE, no response issued.
- RESP:
  - rsp_valid=1, with rsp_data, rsp_tag and rsp_id stable until rsp_ready=1 at an edge; then go to IDLE.
  - flush=1 in RESP drops the response (rsp_valid deasserts next cycle) and goes to IDLE.
- Latency:
  - Handshake at edge E0 → div_valid high in cycle E0..E1.
  - div_finish seen at edge Ek → rsp_valid from Ek onward.
  - Earliest re-grant is the cycle after response acceptance; there is no overlap of requests.
- div_flush is high only in the cycles named above; otherwise 0.
- Divide-by-zero and signed overflow are resolved by the divider; the arbiter passes div_out unmodified.
- req_ready never asserts outside IDLE. Requesters must hold req_* stable until granted.
- rst asserted mid-operation returns to IDLE immediately, with all outputs cleared.

Test Plan:
- Single request: req0, dividend 0x7D0, divisor 0x3, unsign=1, rem=0, tag 5 → one div_valid pulse, then rsp_valid with rsp_data=0x29A, rsp_id=0, rsp_tag=5. Repeat with rem=1 → rsp_data=0x2.
- Signed: dividend 0xFFFFFFF9, divisor 0x2, unsign=0 → rsp_data=0xFFFFFFFD; with rem=1 → 0xFFFFFFFF.
- Contention: req0 and req1 both valid after reset → req0 granted first, then req1 after the response, rr_ptr=0 afterwards. A second simultaneous pair is again served as req0 then req1. If req1 alone is pending while rr_ptr=1, req1 is granted.
- Backpressure: rsp_ready held low 5 cycles in RESP → rsp_valid and rsp_data stable, no req_ready asserted. rsp_ready=1 → next grant one cycle later.
- Flush: flush pulsed in BUSY 3 cycles after issue → div_flush=1 that cycle, no rsp_valid, state IDLE. Flush coincident with div_finish → no response. Flush in RESP → response dropped.
- Watchdog: divider model that never asserts finish, TIMEOUT=8 → timeout_err single pulse plus div_flush, 8 cycles after entering BUSY; the next request then completes normally.
